// File: rtl/project_select_ctrl_pkg.sv
// Shared definitions for the project select controller: FSM encoding,
// register offsets within the Wishbone window and register field positions.
package project_select_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ENABLE = 2'd2
  } state_e;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] OFS_SEL    = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_GUARD  = 4'h8;

  // Field positions shared by SEL and STATUS
  localparam int unsigned IDX_LSB   = 0;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned EN_BIT    = 5;
  localparam int unsigned BUSY_BIT  = 8;
  localparam int unsigned STATE_LSB = 9;
  localparam int unsigned STATE_W   = 2;
  localparam int unsigned GUARD_W   = 8;

  // Assemble the read-only STATUS word
  function automatic logic [31:0] status_word(input logic en,
                                              input logic [IDX_W-1:0] idx,
                                              input logic busy,
                                              input logic [STATE_W-1:0] st);
    logic [31:0] w;
    w = '0;
    w[IDX_LSB +: IDX_W]     = idx;
    w[EN_BIT]               = en;
    w[BUSY_BIT]             = busy;
    w[STATE_LSB +: STATE_W] = st;
    return w;
  endfunction

endpackage

// File: rtl/psc_wb_regs.sv
// Wishbone slave for the project select controller: address decode,
// single-cycle registered ack, SEL/GUARD register file and STATUS readback.
module psc_wb_regs #(
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
  parameter logic [7:0]  GUARD_RST = 8'd16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        cur_en,
  input  logic [4:0]  cur_idx,
  input  logic        busy,
  input  logic [1:0]  state,
  output logic        sel_en,
  output logic [4:0]  sel_idx,
  output logic [7:0]  guard,
  output logic        sel_wr
);
  import project_select_ctrl_pkg::*;

  logic        decoded;
  logic        held;
  logic        accept;
  logic        wr_lane;
  logic [3:0]  ofs;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign decoded   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  // held blocks a second ack until the master drops stb
  assign accept    = decoded & ~held;
  assign ofs       = wbs_adr_i[3:0];
  assign wr_lane   = accept & wbs_we_i & wbs_sel_i[0];
  assign unused_ok = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

  // Read multiplexer; unmapped offsets and bits read as zero
  always_comb begin
    rd_data = '0;
    case (ofs)
      OFS_SEL: begin
        rd_data[EN_BIT]            = sel_en;
        rd_data[IDX_LSB +: IDX_W]  = sel_idx;
      end
      OFS_STATUS: rd_data = status_word(cur_en, cur_idx, busy, state);
      OFS_GUARD:  rd_data[GUARD_W-1:0] = guard;
      default:    rd_data = '0;
    endcase
  end

  // Ack/data registers and register-file writes, all landing in the ack cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      held      <= 1'b0;
      sel_en    <= 1'b0;
      sel_idx   <= '0;
      guard     <= GUARD_RST;
      sel_wr    <= 1'b0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && !wbs_we_i) ? rd_data : '0;
      held      <= wbs_stb_i & (held | decoded);
      sel_wr    <= wr_lane && (ofs == OFS_SEL);
      if (wr_lane) begin
        case (ofs)
          OFS_SEL: begin
            sel_en  <= wbs_dat_i[EN_BIT];
            sel_idx <= wbs_dat_i[IDX_LSB +: IDX_W];
          end
          OFS_GUARD: guard <= wbs_dat_i[GUARD_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/project_select_ctrl.sv
// Project select controller: switches the one-hot project enable through a
// guarded drain period so two projects are never enabled at once.
module project_select_ctrl #(
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
  parameter logic [7:0]  GUARD_RST = 8'd16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] active,
  output logic        busy
);
  import project_select_ctrl_pkg::*;

  state_e     state;
  state_e     state_nxt;
  logic       sel_en;
  logic [4:0] sel_idx;
  logic [7:0] guard;
  logic       sel_wr;
  logic       pend_en;
  logic [4:0] pend_idx;
  logic       cur_en;
  logic [4:0] cur_idx;
  logic [7:0] cnt;
  logic       restart;

  psc_wb_regs #(
    .BASE_ADR (BASE_ADR),
    .GUARD_RST(GUARD_RST)
  ) u_regs (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .cur_en   (cur_en),
    .cur_idx  (cur_idx),
    .busy     (busy),
    .state    (state),
    .sel_en   (sel_en),
    .sel_idx  (sel_idx),
    .guard    (guard),
    .sel_wr   (sel_wr)
  );

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a SEL write during DRAIN holds the FSM there
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (sel_wr || restart) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!sel_wr && cnt == '0) state_nxt = ST_ENABLE;
      ST_ENABLE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Pending/current selection and guard counter.
  // A SEL write in the ENABLE cycle cannot be seen by IDLE directly, so it is
  // remembered in restart and consumed on the following IDLE cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pend_en  <= 1'b0;
      pend_idx <= '0;
      cur_en   <= 1'b0;
      cur_idx  <= '0;
      cnt      <= '0;
      restart  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          restart <= 1'b0;
          if (sel_wr) begin
            pend_en  <= sel_en;
            pend_idx <= sel_idx;
            cnt      <= guard;
          end else if (restart) begin
            cnt <= guard;
          end
        end
        ST_DRAIN: begin
          if (sel_wr) begin
            pend_en  <= sel_en;
            pend_idx <= sel_idx;
            cnt      <= guard;
          end else if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_ENABLE: begin
          cur_en  <= pend_en;
          cur_idx <= pend_idx;
          if (sel_wr) begin
            pend_en  <= sel_en;
            pend_idx <= sel_idx;
            restart  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: enable vector only driven from committed selection while idle
  always_comb begin
    busy   = (state != ST_IDLE);
    active = '0;
    if (state == ST_IDLE && cur_en) active[cur_idx] = 1'b1;
  end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Self-checking bench for project_select_ctrl: Wishbone reads go through a
// scoreboard queue, switch latency and enable-vector safety are monitored.
module tb_project_select_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] active;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int multi  = 0;
  int leak   = 0;
  int bit1   = 0;
  logic [31:0] sb_q[$];

  project_select_ctrl #(
    .BASE_ADR (BASE),
    .GUARD_RST(8'd16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .active   (active),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Continuous safety monitor on the enable vector
  always @(negedge clk) begin
    if ($countones(active) > 1) multi++;
    if (busy && active != '0) leak++;
    if (active[1]) bit1++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic acked);
    acked = 1'b0;
    rd    = '0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1'b1;
        rd    = rdat;
        break;
      end
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [31:0] rd;
    logic        acked;
    wb_xfer(1'b1, a, d, s, rd, acked);
    check({tag, "_ack"}, {31'd0, acked}, 32'd1);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic [31:0] e;
    logic        acked;
    sb_q.push_back(exp);
    wb_xfer(1'b0, a, '0, 4'hF, rd, acked);
    e = sb_q.pop_front();
    if (!acked) check({tag, "_ack"}, 32'd0, 32'd1);
    else        check(tag, rd, e);
  endtask

  // Wait for busy to fall; n counts cycles from the ack cycle to active valid
  task automatic wait_switch(input string tag, input int guard);
    int n;
    int bc;
    logic done;
    n = 0; bc = 0; done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      else begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_lat"}, n, guard + 3);
    check({tag, "_busy"}, bc, guard + 2);
  endtask

  initial begin
    int cnt_nz;
    int acks;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_active", active, '0);
    check("rst_busy", {31'd0, busy}, '0);
    check("rst_ack", {31'd0, ack}, '0);
    check("rst_dat", rdat, '0);
    wb_read("rst_status", BASE + 32'h4, 32'h000);
    wb_read("rst_guard", BASE + 32'h8, 32'h010);
    wb_read("rst_sel", BASE + 32'h0, 32'h000);

    // Select project 5 with default guard of 16
    wb_write("sel25", BASE, 32'h25, 4'hF);
    wait_switch("sw25", 16);
    check("act25", active, 32'h0000_0020);
    wb_read("status25", BASE + 32'h4, 32'h025);
    wb_read("sel25_rb", BASE, 32'h025);

    // Guard zero: a single drain cycle
    wb_write("guard0", BASE + 32'h8, 32'h0, 4'hF);
    wb_read("guard0_rb", BASE + 32'h8, 32'h0);
    wb_write("sel23", BASE, 32'h23, 4'hF);
    wait_switch("sw23", 0);
    check("act23", active, 32'h0000_0008);

    // Restart mid-drain
    wb_write("guard16", BASE + 32'h8, 32'h10, 4'hF);
    wb_write("sel21", BASE, 32'h21, 4'hF);
    repeat (5) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_active", active, '0);
    wb_write("sel27", BASE, 32'h27, 4'hF);
    wait_switch("sw27", 16);
    check("act27", active, 32'h0000_0080);

    // Disable from project 5
    wb_write("sel25b", BASE, 32'h25, 4'hF);
    wait_switch("sw25b", 16);
    check("act25b", active, 32'h0000_0020);
    wb_write("sel00", BASE, 32'h00, 4'hF);
    wait_switch("sw00", 16);
    check("act00", active, '0);
    wb_read("status00", BASE + 32'h4, 32'h000);

    // Lane 0 disabled write is acked but ignored; offset 0xC is a hole
    wb_write("lane0off", BASE, 32'h27, 4'b1110);
    @(negedge clk);
    check("lane0_busy", {31'd0, busy}, '0);
    wb_read("lane0_sel", BASE, 32'h000);
    wb_write("hole_wr", BASE + 32'hC, 32'hFF, 4'hF);
    wb_read("hole_rd", BASE + 32'hC, 32'h0);

    // Ack fires once while stb stays high
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    check("ack_once", acks, 1);
    @(negedge clk);
    check("dat_idle", rdat, '0);

    // Reset in the middle of a drain
    wb_write("guard5", BASE + 32'h8, 32'h05, 4'hF);
    wb_write("sel25c", BASE, 32'h25, 4'hF);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_active", active, '0);
    check("post_rst_busy", {31'd0, busy}, '0);
    cnt_nz = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (active != '0 || busy) cnt_nz++;
    end
    check("post_rst_quiet", cnt_nz, 0);
    wb_read("post_rst_status", BASE + 32'h4, 32'h000);
    wb_read("post_rst_guard", BASE + 32'h8, 32'h010);

    // Out-of-window access is not acknowledged
    begin
      logic [31:0] rd;
      logic        acked;
      wb_xfer(1'b0, BASE + 32'h10, '0, 4'hF, rd, acked);
      check("oow_noack", {31'd0, acked}, '0);
    end

    check("onehot", multi, 0);
    check("drain_leak", leak, 0);
    check("bit1_never", bit1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
